secure_subsys_axi_isolate_ctrl: RTL and testbench

//   Traffic controller on the secure-subsystem AXI master port, in front of the async CDC.

---
 rtl/secure_subsys_axi_isolate_ctrl.sv | 164 ++++++++++++++++
 tb/tb_secure_subsys_axi_isolate_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/secure_subsys_axi_isolate_ctrl.sv
// AXI master-port traffic controller: caps outstanding AW/AR, drains and isolates on request.
// Optional drain timeout is compiled in with `define AXI_ISO_TIMEOUT_EN.
module secure_subsys_axi_isolate_ctrl #(
    parameter int unsigned MaxTrans      = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic isolate_req_i,
    output logic isolated_o,
    output logic timeout_o,
    output logic proto_err_o,
    input  logic s_aw_valid_i,
    output logic s_aw_ready_o,
    output logic m_aw_valid_o,
    input  logic m_aw_ready_i,
    input  logic s_w_valid_i,
    output logic s_w_ready_o,
    output logic m_w_valid_o,
    input  logic m_w_ready_i,
    output logic s_b_valid_o,
    input  logic s_b_ready_i,
    input  logic m_b_valid_i,
    output logic m_b_ready_o,
    input  logic s_ar_valid_i,
    output logic s_ar_ready_o,
    output logic m_ar_valid_o,
    input  logic m_ar_ready_i,
    output logic s_r_valid_o,
    input  logic s_r_ready_i,
    input  logic m_r_valid_i,
    output logic m_r_ready_o,
    input  logic m_r_last_i
);

    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

    typedef enum logic [1:0] {StRun, StDrain, StIsolated} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic            isolated_q, isolated_d;
    logic            aw_open, ar_open, aw_hs, ar_hs, b_hs, r_last_hs;
    logic            wr_err, rd_err, cnt_idle, timer_exp;

    // Gating depends only on registered state, so there is no valid->ready comb path.
    assign aw_open   = (state_q == StRun) && (wr_cnt_q < CntMax);
    assign ar_open   = (state_q == StRun) && (rd_cnt_q < CntMax);
    assign cnt_idle  = (wr_cnt_q == '0) && (rd_cnt_q == '0);

    assign m_aw_valid_o = s_aw_valid_i & aw_open;
    assign s_aw_ready_o = m_aw_ready_i & aw_open;
    assign m_ar_valid_o = s_ar_valid_i & ar_open;
    assign s_ar_ready_o = m_ar_ready_i & ar_open;

    assign m_w_valid_o = s_w_valid_i;
    assign s_w_ready_o = m_w_ready_i;
    assign s_b_valid_o = m_b_valid_i;
    assign m_b_ready_o = s_b_ready_i;
    assign s_r_valid_o = m_r_valid_i;
    assign m_r_ready_o = s_r_ready_i;

    assign aw_hs     = s_aw_valid_i & m_aw_ready_i & aw_open;
    assign ar_hs     = s_ar_valid_i & m_ar_ready_i & ar_open;
    assign b_hs      = m_b_valid_i & s_b_ready_i;
    assign r_last_hs = m_r_valid_i & s_r_ready_i & m_r_last_i;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_err   = 1'b0;
        rd_err   = 1'b0;
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
        end else if (!aw_hs && b_hs) begin
            if (wr_cnt_q == '0) wr_err = 1'b1;
            else                wr_cnt_d = wr_cnt_q - CntW'(1);
        end
        if (ar_hs && !r_last_hs) begin
            rd_cnt_d = rd_cnt_q + CntW'(1);
        end else if (!ar_hs && r_last_hs) begin
            if (rd_cnt_q == '0) rd_err = 1'b1;
            else                rd_cnt_d = rd_cnt_q - CntW'(1);
        end
    end

    assign proto_err_o = wr_err | rd_err;

`ifdef AXI_ISO_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TimeoutCycles);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);

    logic [TmrW-1:0] timer_q, timer_d;
    logic            timeout_q, timeout_d;

    assign timer_exp = (timer_q == TmrLast);

    always_comb begin
        timer_d   = (state_q == StDrain && state_d == StDrain) ? timer_q + TmrW'(1) : '0;
        timeout_d = timeout_q;
        if (state_d != StIsolated) begin
            timeout_d = 1'b0;
        end else if (state_q == StDrain && !cnt_idle) begin
            // Leaving DRAIN with work outstanding can only be the forced timeout path.
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timer_exp = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                // Already idle with nothing accepted this cycle: isolate without a DRAIN stop.
                if (isolate_req_i) begin
                    state_d = (cnt_idle && !aw_hs && !ar_hs) ? StIsolated : StDrain;
                end
            end
            StDrain: begin
                if (!isolate_req_i)  state_d = StRun;
                else if (cnt_idle)   state_d = StIsolated;
                else if (timer_exp)  state_d = StIsolated;
            end
            StIsolated: begin
                if (!isolate_req_i) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
        isolated_d = (state_d == StIsolated);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StRun;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            isolated_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            isolated_q <= isolated_d;
        end
    end

    assign isolated_o = isolated_q;

endmodule

// File: tb/tb_secure_subsys_axi_isolate_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-count model of the isolation controller.
module tb_secure_subsys_axi_isolate_ctrl;

    localparam int MAXT = 2;
    localparam int TOC  = 16;
`ifdef AXI_ISO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic isolate_req_i = 1'b0;
    logic isolated_o, timeout_o, proto_err_o;
    logic s_aw_valid_i = 1'b0, m_aw_ready_i = 1'b1, s_aw_ready_o, m_aw_valid_o;
    logic s_w_valid_i = 1'b0, m_w_ready_i = 1'b1, s_w_ready_o, m_w_valid_o;
    logic m_b_valid_i = 1'b0, s_b_ready_i = 1'b1, s_b_valid_o, m_b_ready_o;
    logic s_ar_valid_i = 1'b0, m_ar_ready_i = 1'b1, s_ar_ready_o, m_ar_valid_o;
    logic m_r_valid_i = 1'b0, s_r_ready_i = 1'b1, s_r_valid_o, m_r_ready_o;
    logic m_r_last_i = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Model: outstanding counts and mode 0=run, 1=drain, 2=isolated.
    int m_wr = 0, m_rd = 0, m_mode = 0, m_timer = 0;
    bit m_tout = 1'b0;

    secure_subsys_axi_isolate_ctrl #(.MaxTrans(MAXT), .TimeoutCycles(TOC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .isolate_req_i(isolate_req_i),
        .isolated_o(isolated_o), .timeout_o(timeout_o), .proto_err_o(proto_err_o),
        .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o),
        .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
        .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o),
        .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i),
        .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i),
        .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o),
        .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
        .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
        .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i),
        .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o),
        .m_r_last_i(m_r_last_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit aw_acc();
        return s_aw_valid_i && m_aw_ready_i && m_mode == 0 && m_wr < MAXT;
    endfunction
    function automatic bit ar_acc();
        return s_ar_valid_i && m_ar_ready_i && m_mode == 0 && m_rd < MAXT;
    endfunction
    function automatic bit b_done();
        return m_b_valid_i && s_b_ready_i;
    endfunction
    function automatic bit r_done();
        return m_r_valid_i && s_r_ready_i && m_r_last_i;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin : model
        int nwr, nrd;
        if (!rst_ni) begin
            m_wr <= 0; m_rd <= 0; m_mode <= 0; m_timer <= 0; m_tout <= 1'b0;
        end else begin
            nwr = m_wr + int'(aw_acc()) - int'(b_done());
            nrd = m_rd + int'(ar_acc()) - int'(r_done());
            m_wr <= (nwr < 0) ? 0 : nwr;
            m_rd <= (nrd < 0) ? 0 : nrd;
            case (m_mode)
                0: if (isolate_req_i) begin
                    m_timer <= 0;
                    m_mode  <= (m_wr == 0 && m_rd == 0 && !aw_acc() && !ar_acc()) ? 2 : 1;
                end
                1: begin
                    if (!isolate_req_i) m_mode <= 0;
                    else if (m_wr == 0 && m_rd == 0) m_mode <= 2;
                    else if (TO_EN && m_timer == TOC - 1) begin
                        m_mode <= 2; m_tout <= 1'b1;
                    end else m_timer <= m_timer + 1;
                end
                default: if (!isolate_req_i) begin
                    m_mode <= 0; m_tout <= 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk_i) begin : compare
        logic [12:0] act, exp;
        #2;
        exp = {aw_acc() ? 1'b1 : (s_aw_valid_i && m_mode == 0 && m_wr < MAXT),
               m_aw_ready_i && m_mode == 0 && m_wr < MAXT,
               s_w_valid_i, m_w_ready_i, m_b_valid_i, s_b_ready_i,
               s_ar_valid_i && m_mode == 0 && m_rd < MAXT,
               m_ar_ready_i && m_mode == 0 && m_rd < MAXT,
               m_r_valid_i, s_r_ready_i, m_mode == 2, m_tout,
               (b_done() && m_wr == 0 && !aw_acc()) || (r_done() && m_rd == 0 && !ar_acc())};
        act = {m_aw_valid_o, s_aw_ready_o, m_w_valid_o, s_w_ready_o, s_b_valid_o, m_b_ready_o,
               m_ar_valid_o, s_ar_ready_o, s_r_valid_o, m_r_ready_o, isolated_o, timeout_o,
               proto_err_o};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t: outputs %b, model requires %b", $time, act, exp);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk_i);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        repeat (3) nxt();
        rst_ni = 1'b1;
        nxt(); #4;
        chk("rst_isolated", isolated_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_proto", proto_err_o, 0);
        chk("rst_aw_ready", s_aw_ready_o, 1);
        chk("rst_ar_ready", s_ar_ready_o, 1);

        // Three back-to-back AWs with no B: third stalls until one B returns.
        nxt(); s_aw_valid_i = 1; #4 chk("aw1_ready", s_aw_ready_o, 1);
        nxt(); #4 chk("aw2_ready", s_aw_ready_o, 1);
        nxt(); #4 chk("aw3_stall", s_aw_ready_o, 0);
        chk("aw3_mvalid", m_aw_valid_o, 0);
        m_b_valid_i = 1;
        nxt(); m_b_valid_i = 0; #4 chk("aw3_accept", s_aw_ready_o, 1);
        nxt(); s_aw_valid_i = 0; m_b_valid_i = 1;
        nxt();
        nxt(); m_b_valid_i = 0; #4 chk("model_wr_zero", m_wr, 0);

        // AR and last-R in the same cycle with one read outstanding.
        nxt(); s_ar_valid_i = 1;
        nxt(); m_r_valid_i = 1; m_r_last_i = 1; #4 chk("ar_r_same_proto", proto_err_o, 0);
        chk("ar_r_same_ready", s_ar_ready_o, 1);
        nxt(); s_ar_valid_i = 0; m_r_valid_i = 0; #4 chk("model_rd_one", m_rd, 1);
        nxt(); m_r_valid_i = 1;
        nxt(); m_r_valid_i = 0; m_r_last_i = 0;

        // Drain with one write and two reads outstanding.
        nxt(); s_aw_valid_i = 1; s_ar_valid_i = 1;
        nxt(); s_aw_valid_i = 0;
        nxt(); s_ar_valid_i = 0; isolate_req_i = 1;
        nxt(); s_aw_valid_i = 1; s_ar_valid_i = 1; m_b_valid_i = 1;
        #4 chk("drain_aw_block", s_aw_ready_o, 0);
        chk("drain_ar_block", s_ar_ready_o, 0);
        chk("drain_ar_mvalid", m_ar_valid_o, 0);
        nxt(); m_b_valid_i = 0; m_r_valid_i = 1; m_r_last_i = 1;
        nxt();
        nxt(); m_r_valid_i = 0; m_r_last_i = 0; #4 chk("drain_not_yet", isolated_o, 0);
        nxt(); #4 chk("drain_isolated", isolated_o, 1);
        chk("iso_aw_block", s_aw_ready_o, 0);
        isolate_req_i = 0;
        nxt(); s_aw_valid_i = 0; s_ar_valid_i = 0; #4 chk("release_iso", isolated_o, 0);
        chk("release_aw_open", s_aw_ready_o, 1);

        // Isolate while idle, then a stray B.
        nxt(); isolate_req_i = 1;
        nxt(); m_b_valid_i = 1; #4 chk("idle_isolated", isolated_o, 1);
        chk("stray_b_proto", proto_err_o, 1);
        nxt(); m_b_valid_i = 0; #4 chk("proto_pulse_end", proto_err_o, 0);
        isolate_req_i = 0;
        nxt();

`ifdef AXI_ISO_TIMEOUT_EN
        nxt(); s_aw_valid_i = 1;
        nxt(); s_aw_valid_i = 0; isolate_req_i = 1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            nxt(); #2;
            n = i;
            if (isolated_o) break;
        end
        chk("timeout_cycles", n, 17);
        chk("timeout_flag", timeout_o, 1);
        isolate_req_i = 0;
        nxt(); #4 chk("timeout_clr_iso", isolated_o, 0);
        chk("timeout_clr_flag", timeout_o, 0);
        m_b_valid_i = 1;
        nxt(); m_b_valid_i = 0;
`endif

        // Reset in the middle of a drain with two writes outstanding.
        nxt(); s_aw_valid_i = 1;
        nxt();
        nxt(); s_aw_valid_i = 0; isolate_req_i = 1;
        nxt();
        nxt(); #4 chk("mid_drain", isolated_o, 0);
        chk("mid_drain_block", s_aw_ready_o, 0);
        #1 rst_ni = 0;
        #2 chk("rst_mid_aw_open", s_aw_ready_o, 1);
        chk("rst_mid_iso", isolated_o, 0);
        isolate_req_i = 0;
        nxt(); rst_ni = 1;
        nxt(); #4 chk("post_rst_model", m_wr, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            nxt();
            s_aw_valid_i = 1'($urandom_range(0, 1));
            s_ar_valid_i = 1'($urandom_range(0, 1));
            s_w_valid_i  = 1'($urandom_range(0, 1));
            m_aw_ready_i = ($urandom_range(0, 3) != 0);
            m_ar_ready_i = ($urandom_range(0, 3) != 0);
            m_w_ready_i  = 1'($urandom_range(0, 1));
            s_b_ready_i  = ($urandom_range(0, 3) != 0);
            s_r_ready_i  = ($urandom_range(0, 3) != 0);
            m_b_valid_i  = ($urandom_range(0, 2) == 0);
            m_r_valid_i  = 1'($urandom_range(0, 1));
            m_r_last_i   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) isolate_req_i = ~isolate_req_i;
            rst_ni = ($urandom_range(0, 799) != 0);
        end
        nxt(); rst_ni = 1;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
